// File: rtl/wb_pkg.sv
// Shared encodings for the MEM/WB stage: load-type codes, write-back source codes
// and the register-address width.
package wb_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    LT_W  = 3'b000,
    LT_H  = 3'b001,
    LT_HU = 3'b010,
    LT_B  = 3'b011,
    LT_BU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10
  } wb_sel_e;

endpackage

// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: MEM-stage instruction fields in, register-file write port
// and retire/misalign status out.
interface mem_wb_if
  import wb_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic                  i_stall;
  logic                  i_flush;
  logic                  i_valid;
  logic                  i_reg_write;
  logic [1:0]            i_wb_sel;
  logic [2:0]            i_load_type;
  logic [REG_ADDR_W-1:0] i_write_register;
  logic [31:0]           i_alu_result;
  logic [31:0]           i_mem_rdata;
  logic [31:0]           i_pc_plus4;

  logic                  o_valid;
  logic                  o_reg_write;
  logic [REG_ADDR_W-1:0] o_write_register;
  logic [31:0]           o_write_data;
  logic                  o_misalign;
  logic [CNT_W-1:0]      o_retired;

  modport master (
    output i_stall, i_flush, i_valid, i_reg_write, i_wb_sel, i_load_type,
           i_write_register, i_alu_result, i_mem_rdata, i_pc_plus4,
    input  o_valid, o_reg_write, o_write_register, o_write_data, o_misalign,
           o_retired
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_reg_write, i_wb_sel, i_load_type,
           i_write_register, i_alu_result, i_mem_rdata, i_pc_plus4,
    output o_valid, o_reg_write, o_write_register, o_write_data, o_misalign,
           o_retired
  );

endinterface

// File: rtl/load_aligner.sv
// Little-endian load lane extraction with sign/zero extension; flags loads whose
// address is not naturally aligned for their size.
module load_aligner
  import wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [15:0] half;
  logic [7:0]  byte_lane;

  always_comb begin
    half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
  end

  // Unused load-type codes behave as a full-word load.
  always_comb begin
    data       = rdata;
    misaligned = (addr != 2'd0);
    case (load_type)
      LT_H: begin
        data       = {{16{half[15]}}, half};
        misaligned = addr[0];
      end
      LT_HU: begin
        data       = {16'h0000, half};
        misaligned = addr[0];
      end
      LT_B: begin
        data       = {{24{byte_lane[7]}}, byte_lane};
        misaligned = 1'b0;
      end
      LT_BU: begin
        data       = {24'h000000, byte_lane};
        misaligned = 1'b0;
      end
      default: begin
        data       = rdata;
        misaligned = (addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the write-back value, gates the register-file
// write, reports misaligned loads and counts retired instructions.
module mem_wb_stage
  import wb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic   clk,
  input  logic   reset,
  mem_wb_if.slave bus
);

  logic [31:0]           load_data;
  logic                  align_err;
  logic                  misaligned;
  logic [31:0]           wb_data;

  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_register_q, write_register_d;
  logic [31:0]           write_data_q, write_data_d;
  logic                  misalign_q, misalign_d;
  logic [CNT_W-1:0]      retired_q, retired_d;

  load_aligner u_load_aligner (
    .rdata      (bus.i_mem_rdata),
    .addr       (bus.i_alu_result[1:0]),
    .load_type  (bus.i_load_type),
    .data       (load_data),
    .misaligned (align_err)
  );

  assign misaligned = bus.i_valid & (bus.i_wb_sel == WB_MEM) & align_err;

  // The reserved select code falls through to the ALU result.
  always_comb begin
    case (bus.i_wb_sel)
      WB_MEM:  wb_data = load_data;
      WB_LINK: wb_data = bus.i_pc_plus4;
      default: wb_data = bus.i_alu_result;
    endcase
  end

  always_comb begin
    valid_d          = valid_q;
    reg_write_d      = reg_write_q;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    misalign_d       = misalign_q;
    retired_d        = retired_q;
    if (bus.i_flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      misalign_d  = 1'b0;
    end else if (!bus.i_stall) begin
      valid_d          = bus.i_valid;
      reg_write_d      = bus.i_valid & bus.i_reg_write &
                         (bus.i_write_register != '0) & ~misaligned;
      write_register_d = bus.i_write_register;
      write_data_d     = wb_data;
      misalign_d       = misaligned;
      if (bus.i_valid && !misaligned) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q          <= 1'b0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      misalign_q       <= 1'b0;
      retired_q        <= '0;
    end else begin
      valid_q          <= valid_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      misalign_q       <= misalign_d;
      retired_q        <= retired_d;
    end
  end

  assign bus.o_valid          = valid_q;
  assign bus.o_reg_write      = reg_write_q;
  assign bus.o_write_register = write_register_q;
  assign bus.o_write_data     = write_data_q;
  assign bus.o_misalign       = misalign_q;
  assign bus.o_retired        = retired_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back select for the 5-stage MIPS pipeline.
- Captures the MEM-stage instruction, extracts and extends load data, and selects the write-back value (ALU result, load data or link address).
- Drives the register file write port (write enable, destination, data) and the retire/misalign status.
- Sits directly upstream of the register file write port.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_stall  input  1  hold: all state keeps its value this edge.
- i_flush  input  1  insert bubble this edge; priority over i_stall.
- i_valid  input  1  MEM-stage slot holds a real instruction.
- i_reg_write  input  1  instruction writes a GPR.
- i_wb_sel  input  2  write-back source: 00 ALU, 01 load, 10 link, 11 reserved (treated as ALU).
- i_load_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101-111 treated as LW.
- i_write_register  input  5  destination GPR.
- i_alu_result  input  32  ALU result; also the load byte address.
- i_mem_rdata  input  32  word read from data memory, valid in the same cycle.
- i_pc_plus4  input  32  link value for JAL/JALR.
- o_valid  output  1  WB slot holds a real instruction.
- o_reg_write  output  1  register file write enable.
- o_write_register  output  5  register file write address.
- o_write_data  output  32  register file write data.
- o_misalign  output  1  one-cycle flag: the latched load was misaligned.
- o_retired  output  CNT_W  count of valid instructions accepted into WB.

Behaviour:
- Reset (asynchronous, immediate): o_valid=0, o_reg_write=0, o_write_register=0, o_write_data=0, o_misalign=0, o_retired=0.
- Latency is 1 cycle. Load extraction and the write-back select are combinational in the MEM cycle. Every output is a pure register output.
- Per edge, priority is reset > i_flush > i_stall > normal load.
- Flush: o_valid=0, o_reg_write=0, o_misalign=0. o_write_register and o_write_data hold their values. o_retired unchanged.
- Stall (no flush): every register holds. A held o_reg_write re-writes the same value, which is idempotent and allowed.
- Normal edge: o_valid<=i_valid; o_write_register<=i_write_register; o_write_data<=selected value.
- Normal edge: o_reg_write<=i_valid & i_reg_write & (i_write_register!=0) & ~misaligned.
- Load extraction (little-endian, lane = i_alu_result[1:0]):
  - LW: whole word.
  - LH/LHU: halfword at bits [16*a1+15 : 16*a1], where a1 = i_alu_result[1]; sign-extended for LH, zero-extended for LHU.
  - LB/LBU: byte at bits [8*a+7 : 8*a], where a = i_alu_result[1:0]; sign-extended for LB, zero-extended for LBU.
- Misaligned: i_valid & i_wb_sel==01 & ((LW & addr[1:0]!=0) | ((LH|LHU) & addr[0]!=0)).
  - The write is suppressed.
  - o_misalign=1 for exactly the one cycle the instruction occupies WB (held if stalled, cleared on the next load/flush).
  - o_write_data still latches the extracted value.
- Retire counter: increments by 1 on a normal edge when i_valid & ~misaligned. It wraps from 2^CNT_W-1 to 0.
- i_wb_sel is ignored when i_reg_write=0. Misalign is checked only when i_wb_sel==01.
- Reset asserted mid-stall or mid-flush clears everything immediately. First capture happens on the first edge after reset deasserts.

Decomposition:
- Package wb_pkg holds:
  - load-type codes LT_W/LT_H/LT_HU/LT_B/LT_BU;
  - write-back select codes WB_ALU/WB_MEM/WB_LINK;
  - the register-address width constant (5).
- Sub-module load_aligner: purely combinational, inputs (rdata, addr[1:0], load_type), outputs (data[31:0], misaligned).
- mem_wb_stage instantiates load_aligner and contains the registers, select mux and counter.

Test Plan:
- Reset then idle → all outputs 0; o_retired=0.
- ALU write: valid, reg_write, wb_sel=00, dest=8, alu=0x0000_1234 → next cycle o_reg_write=1, o_write_register=8, o_write_data=0x0000_1234, o_retired=1.
- Loads with rdata=0x80FF_7F01:
  - LB addr 0x...3 → 0xFFFF_FF80.
  - LBU addr 0x...3 → 0x0000_0080.
  - LH addr 0x...2 → 0xFFFF_80FF.
  - LHU addr 0x...0 → 0x0000_7F01.
  - LW addr 0x...0 → 0x80FF_7F01.
- Misaligned LW addr 0x...2, dest=9 → o_reg_write=0, o_misalign=1 for one cycle, o_retired unchanged. Dest=0 with a valid ALU write → o_reg_write=0, o_retired increments.
- JAL link: wb_sel=10, dest=31, pc_plus4=0x0040_0008 → o_write_data=0x0040_0008. The next edge with i_stall=1 holds all outputs. i_flush and i_stall together → o_valid=0, o_reg_write=0.
- Counter wrap with CNT_W=4: 16 valid instructions → o_retired returns to 0. Assert reset asynchronously between edges → outputs 0 immediately.
